// File: rtl/btn_evt_pkg.sv
// ---------------------------------------------------------------------------
// btn_evt_pkg
// Shared definitions for the push-button conditioner: event codes handed to
// the LED pattern block and the debounce FSM state encoding.
// ---------------------------------------------------------------------------
package btn_evt_pkg;

    // Event codes presented on evt_code; 0 never appears while evt_valid=1.
    localparam logic [1:0] EVT_PRESS   = 2'd1;
    localparam logic [1:0] EVT_RELEASE = 2'd2;
    localparam logic [1:0] EVT_LONG    = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StPressDb,
        StHeld,
        StReleaseDb
    } btn_state_e;

endpackage

// File: rtl/btn_sync.sv
// ---------------------------------------------------------------------------
// btn_sync
// Two-flop synchroniser for asynchronous pin inputs, with a per-bit reset
// value so the chain can idle at a pin's inactive level.
//
// Ports:
//   i_clk      destination clock
//   i_rst_n    synchronous active-low reset
//   i_rst_val  value loaded into both stages during reset
//   i_d        asynchronous input
//   o_q        synchronised output (two-cycle latency)
// ---------------------------------------------------------------------------
module btn_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_rst_val,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= i_rst_val;
            r_sync <= i_rst_val;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Push-button conditioner: synchronises the raw pin, debounces press and
// release, optionally detects long presses, and offers PRESS/RELEASE/LONG
// events through a registered one-entry valid/ready buffer.
//
// Optional feature: define BTN_LONG_PRESS_EN to include the hold counter and
// the LONG event. Without it, code 3 is never produced.
//
// Ports:
//   sys_clk       single clock, rising edge
//   sys_rst_n     synchronous active-low reset
//   btn_raw       asynchronous button pin
//   btn_level     debounced pressed level (1 = pressed)
//   evt_valid     event buffer holds an event
//   evt_code      1 = PRESS, 2 = RELEASE, 3 = LONG
//   evt_ready     consumer accepts when evt_valid & evt_ready
//   evt_overflow  sticky: an event was dropped because the buffer was full
// ---------------------------------------------------------------------------
module btn_debounce
    import btn_evt_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 27_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = CLK_HZ / 100,
    parameter int unsigned LONG_CYCLES     = CLK_HZ,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       btn_raw,
    output logic       btn_level,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    input  logic       evt_ready,
    output logic       evt_overflow
);

    localparam int unsigned     CW      = $clog2(LONG_CYCLES + 1);
    localparam logic [CW-1:0]   DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // ---------------------------------------------------------------------
    // Synchroniser; idles at the released pin level
    // ---------------------------------------------------------------------
    logic w_rel_level;
    logic w_sync;
    logic w_btn_s;

    assign w_rel_level = BTN_ACTIVE_LOW;

    btn_sync #(
        .WIDTH (1)
    ) u_btn_sync (
        .i_clk     (sys_clk),
        .i_rst_n   (sys_rst_n),
        .i_rst_val (w_rel_level),
        .i_d       (btn_raw),
        .o_q       (w_sync)
    );

    assign w_btn_s = BTN_ACTIVE_LOW ? ~w_sync : w_sync;

    // ---------------------------------------------------------------------
    // Debounce FSM
    // ---------------------------------------------------------------------
    btn_state_e    r_state;
    btn_state_e    w_state_nxt;
    logic [CW-1:0] r_db_cnt;
    logic [CW-1:0] w_db_cnt_nxt;
    logic          r_level;
    logic          w_level_nxt;
    logic          w_press;
    logic          w_release;
    logic          w_long;

`ifdef BTN_LONG_PRESS_EN
    localparam logic [CW-1:0] HOLD_INIT = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] HOLD_PRE  = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_MAX  = CW'(LONG_CYCLES);

    logic [CW-1:0] r_hold_cnt;
    logic [CW-1:0] w_hold_cnt_nxt;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_db_cnt_nxt = r_db_cnt;
        w_level_nxt  = r_level;
        w_press      = 1'b0;
        w_release    = 1'b0;

`ifdef BTN_LONG_PRESS_EN
        // Hold time keeps running through release bounces; saturation makes
        // the LONG strobe a single pulse per press.
        w_hold_cnt_nxt = r_hold_cnt;
        w_long         = 1'b0;
        if ((r_state == StHeld) || (r_state == StReleaseDb)) begin
            if (r_hold_cnt != HOLD_MAX) begin
                w_hold_cnt_nxt = r_hold_cnt + CW'(1);
            end
            w_long = (r_hold_cnt == HOLD_PRE);
        end
`else
        w_long = 1'b0;
`endif

        unique case (r_state)
            StIdle: begin
                if (w_btn_s) begin
                    w_state_nxt  = StPressDb;
                    w_db_cnt_nxt = '0;
                end
            end
            StPressDb: begin
                if (!w_btn_s) begin
                    w_state_nxt = StIdle;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nxt = StHeld;
                    w_level_nxt = 1'b1;
                    w_press     = 1'b1;
`ifdef BTN_LONG_PRESS_EN
                    // Debounce time already counts towards the hold time.
                    w_hold_cnt_nxt = HOLD_INIT;
`endif
                end else begin
                    w_db_cnt_nxt = r_db_cnt + CW'(1);
                end
            end
            StHeld: begin
                if (!w_btn_s) begin
                    w_state_nxt  = StReleaseDb;
                    w_db_cnt_nxt = '0;
                end
            end
            StReleaseDb: begin
                if (w_btn_s) begin
                    w_state_nxt = StHeld;
                end else if (r_db_cnt == DB_LAST) begin
                    // LONG owns this cycle; stay put so RELEASE follows next.
                    if (!w_long) begin
                        w_state_nxt = StIdle;
                        w_level_nxt = 1'b0;
                        w_release   = 1'b1;
                    end
                end else begin
                    w_db_cnt_nxt = r_db_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // At most one of press/release/long is set in any cycle.
    logic       w_emit;
    logic [1:0] w_code;

    assign w_emit = w_press | w_release | w_long;
    assign w_code = w_long ? EVT_LONG : (w_press ? EVT_PRESS : EVT_RELEASE);

    // ---------------------------------------------------------------------
    // State registers and one-entry event buffer
    // ---------------------------------------------------------------------
    logic       r_evt_valid;
    logic [1:0] r_evt_code;
    logic       r_evt_ovf;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state     <= StIdle;
            r_db_cnt    <= '0;
            r_level     <= 1'b0;
            r_evt_valid <= 1'b0;
            r_evt_code  <= 2'd0;
            r_evt_ovf   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_db_cnt <= w_db_cnt_nxt;
            r_level  <= w_level_nxt;
            if (w_emit) begin
                // A slot being accepted this cycle can take the new event.
                if (!r_evt_valid || evt_ready) begin
                    r_evt_valid <= 1'b1;
                    r_evt_code  <= w_code;
                end else begin
                    r_evt_ovf <= 1'b1;
                end
            end else if (r_evt_valid && evt_ready) begin
                r_evt_valid <= 1'b0;
            end
        end
    end

`ifdef BTN_LONG_PRESS_EN
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_hold_cnt <= '0;
        end else begin
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end
`endif

    assign btn_level    = r_level;
    assign evt_valid    = r_evt_valid;
    assign evt_code     = r_evt_code;
    assign evt_overflow = r_evt_ovf;

endmodule

// File: tb/tb_btn_debounce.sv
// ---------------------------------------------------------------------------
// tb_btn_debounce
// Scoreboard bench for btn_debounce (DEBOUNCE_CYCLES=4, LONG_CYCLES=20,
// active-low button). A reference model tracks run lengths of the
// synchronised button and pushes each event it expects the buffer to load;
// a monitor pops one entry whenever the DUT loads its buffer.
// ---------------------------------------------------------------------------
module tb_btn_debounce;

    localparam int unsigned D = 4;
    localparam int unsigned L = 20;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       btn_raw   = 1'b1;
    logic       evt_ready = 1'b0;
    logic       btn_level;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       evt_overflow;

    btn_debounce #(
        .CLK_HZ          (27_000_000),
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L),
        .BTN_ACTIVE_LOW  (1'b1)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .evt_valid    (evt_valid),
        .evt_code     (evt_code),
        .evt_ready    (evt_ready),
        .evt_overflow (evt_overflow)
    );

    always #5 sys_clk = ~sys_clk;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc    = 0;

    // Reference model state
    bit          m_s1, m_s2;
    bit          m_level;
    bit          m_long_done;
    bit          m_slot;
    bit          m_ovf;
    int unsigned m_run;
    int unsigned m_press_start;
    logic [1:0]  exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a level change is accepted once the synchronised button has
    // differed from the accepted level on D+1 consecutive edges. LONG fires
    // L edges after the start of the accepted press run, if still pressed.
    initial begin : model
        bit         bs;
        bit         ev;
        logic [1:0] code;
        forever begin
            @(posedge sys_clk);
            cyc++;
            ev   = 1'b0;
            code = 2'd0;
            if (!sys_rst_n) begin
                m_s1        = 1'b0;
                m_s2        = 1'b0;
                m_level     = 1'b0;
                m_long_done = 1'b1;
                m_slot      = 1'b0;
                m_ovf       = 1'b0;
                m_run       = 0;
            end else begin
                bs   = m_s2;
                m_s2 = m_s1;
                m_s1 = ~btn_raw;
`ifdef BTN_LONG_PRESS_EN
                if (m_level && !m_long_done && cyc == m_press_start + L) begin
                    ev          = 1'b1;
                    code        = 2'd3;
                    m_long_done = 1'b1;
                end
`endif
                if (bs != m_level) m_run++;
                else m_run = 0;
                // A LONG on the same edge pushes the release back by one edge.
                if (m_run >= D + 1 && !ev) begin
                    m_run = 0;
                    ev    = 1'b1;
                    if (!m_level) begin
                        m_level       = 1'b1;
                        code          = 2'd1;
                        m_press_start = cyc - D;
                        m_long_done   = 1'b0;
                    end else begin
                        m_level = 1'b0;
                        code    = 2'd2;
                    end
                end
                if (ev) begin
                    if (!m_slot || evt_ready) begin
                        m_slot = 1'b1;
                        exp_q.push_back(code);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end else if (m_slot && evt_ready) begin
                    m_slot = 1'b0;
                end
            end
        end
    end

    // Monitor: compares outputs half a cycle after each edge.
    initial begin : monitor
        bit         p_valid = 1'b0;
        bit         p_ready = 1'b0;
        bit         p_rstn  = 1'b0;
        bit         load;
        logic [1:0] exp_code;
        forever begin
            @(negedge sys_clk);
            if (!p_rstn) begin
                chk("rst_valid", {31'd0, evt_valid}, 32'd0);
                chk("rst_code", {30'd0, evt_code}, 32'd0);
                chk("rst_level", {31'd0, btn_level}, 32'd0);
                chk("rst_overflow", {31'd0, evt_overflow}, 32'd0);
                exp_q.delete();
            end else begin
                chk("btn_level", {31'd0, btn_level}, {31'd0, m_level});
                chk("evt_overflow", {31'd0, evt_overflow}, {31'd0, m_ovf});
                chk("evt_valid", {31'd0, evt_valid}, {31'd0, m_slot});
                load = (evt_valid === 1'b1) && (!p_valid || p_ready);
                if (load) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_event: got code %0d, expected no event (cycle %0d)",
                                 evt_code, cyc);
                    end else begin
                        exp_code = exp_q.pop_front();
                        chk("event_code", {30'd0, evt_code}, {30'd0, exp_code});
                    end
                end else if (exp_q.size() != 0) begin
                    checks++;
                    errors++;
                    exp_code = exp_q.pop_front();
                    $display("FAIL missing_event: got no load, expected code %0d (cycle %0d)",
                             exp_code, cyc);
                end
            end
            p_valid = evt_valid;
            p_ready = evt_ready;
            p_rstn  = sys_rst_n;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic hold_btn(input bit pressed, input int n);
        btn_raw = ~pressed;
        step(n);
    endtask

    initial begin : stimulus
        int dur;
        // Reset
        sys_rst_n = 1'b0;
        step(3);
        sys_rst_n = 1'b1;
        evt_ready = 1'b1;
        step(5);

        // Clean press and release
        hold_btn(1'b1, 12);
        hold_btn(1'b0, 12);

        // Bounce on press
        hold_btn(1'b1, 3);
        hold_btn(1'b0, 1);
        hold_btn(1'b1, 12);
        hold_btn(1'b0, 12);

        // Long press
        hold_btn(1'b1, 30);
        hold_btn(1'b0, 12);

        // Release bounce spanning the LONG edge
        hold_btn(1'b1, 17);
        hold_btn(1'b0, 3);
        hold_btn(1'b1, 2);
        hold_btn(1'b0, 12);

        // Overflow: nothing accepted through press and release
        evt_ready = 1'b0;
        hold_btn(1'b1, 10);
        hold_btn(1'b0, 12);
        evt_ready = 1'b1;
        step(3);
        hold_btn(1'b1, 10);
        hold_btn(1'b0, 12);

        // Accept and new event in the same cycle
        sys_rst_n = 1'b0;
        step(1);
        sys_rst_n = 1'b1;
        evt_ready = 1'b0;
        hold_btn(1'b1, 10);
        btn_raw = 1'b1;
        step(6);
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        step(5);
        evt_ready = 1'b1;
        step(3);

        // Reset mid-hold with the button still down
        hold_btn(1'b1, 10);
        sys_rst_n = 1'b0;
        step(1);
        sys_rst_n = 1'b1;
        step(12);
        hold_btn(1'b0, 12);

        // Randomised segments
        repeat (120) begin
            btn_raw = 1'($urandom_range(0, 1));
            dur     = int'($urandom_range(1, 28));
            repeat (dur) begin
                evt_ready = ($urandom_range(0, 3) != 0);
                sys_rst_n = ($urandom_range(0, 150) != 0);
                step(1);
            end
        end

        sys_rst_n = 1'b1;
        evt_ready = 1'b1;
        hold_btn(1'b0, 30);
        @(negedge sys_clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Push-button conditioner that sits directly upstream of the LED pattern block on the 27 MHz board. It synchronises a raw, bouncing button input, debounces press and release, and detects long presses. It hands PRESS/RELEASE/LONG events to the LED block through a one-entry valid/ready buffer, so the downstream stage can change pattern or mode.

## Interface
- `CLK_HZ`, 27_000_000, board clock frequency; documentation and derived defaults only.
- `DEBOUNCE_CYCLES`, 270_000, stable cycles required to accept a transition (10 ms); must be ≥2.
- `LONG_CYCLES`, 27_000_000, cycles of accepted hold before LONG fires (1 s); must be greater than `DEBOUNCE_CYCLES`.
- `BTN_ACTIVE_LOW`, 1, when 1, `btn_raw`=0 means pressed.

Ports:
- `sys_clk` in 1: single clock; all logic on its rising edge.
- `sys_rst_n` in 1: synchronous, active-low reset.
- `btn_raw` in 1: asynchronous pin input.
- `btn_level` out 1: debounced pressed level (1 = pressed).
- `evt_valid` out 1: event buffer holds an event.
- `evt_code` out 2: 1 = PRESS, 2 = RELEASE, 3 = LONG; 0 is never presented while `evt_valid`=1.
- `evt_ready` in 1: consumer accepts the event on a cycle where `evt_valid & evt_ready`.
- `evt_overflow` out 1: sticky; an event was dropped because the buffer was full.

## Operation
- **Synchroniser:** two flops, reset to the released level. `btn_s` is the synchronised value normalised to active-high.
- **FSM states:** IDLE, PRESS_DB, HELD, RELEASE_DB; reset → IDLE. One debounce counter `db_cnt` and one hold counter `hold_cnt`.
- **IDLE:**
  - `btn_s`=1 → PRESS_DB, `db_cnt`←0.
- **PRESS_DB:**
  - `btn_s`=0 → IDLE (bounce rejected, no event).
  - `db_cnt`==DEBOUNCE_CYCLES-1 → HELD; `btn_level`←1; emit PRESS; `hold_cnt`←DEBOUNCE_CYCLES.
  - Otherwise `db_cnt`++.
- **HELD:**
  - `hold_cnt` increments and saturates at LONG_CYCLES.
  - On the cycle it becomes LONG_CYCLES, emit LONG exactly once per press.
  - `btn_s`=0 → RELEASE_DB, `db_cnt`←0.
- **RELEASE_DB:**
  - `btn_s`=1 → HELD (bounce rejected). `hold_cnt` keeps counting and is not reset.
  - `db_cnt`==DEBOUNCE_CYCLES-1 → IDLE; `btn_level`←0; emit RELEASE.
  - Otherwise `db_cnt`++. `hold_cnt` also keeps counting in this state, so LONG may fire here.
- **Event buffer (one entry):**
  - An emitted event loads the buffer when it is empty, or when it is full and being accepted in the same cycle (new event replaces the accepted one, `evt_valid` stays 1).
  - An event emitted while the buffer is full and not accepted is dropped, and `evt_overflow`←1. The buffered event is unchanged.
  - Acceptance with no new event → `evt_valid`←0.
  - `evt_code` is stable while `evt_valid`=1 and not accepted.
- **Counter widths:** `$clog2(LONG_CYCLES+1)` bits, unsigned; no wrap possible because of saturation.

## Timing
- **Reset values:** `btn_level`=0, `evt_valid`=0, `evt_code`=0, `evt_overflow`=0, state IDLE, both counters 0, synchroniser at the released level.
- **Reset mid-operation:** everything returns to the reset values on the next edge, and any buffered event is lost. A button held through reset produces a fresh PRESS after debounce.
- **Press latency:** count edges from the first edge that samples `btn_raw` pressed.
  - `btn_s`=1 after edge 2.
  - PRESS_DB is entered at edge 3.
  - `btn_level` and `evt_valid` go to 1 at edge 3+DEBOUNCE_CYCLES.
- **Release latency:** symmetric, 3+DEBOUNCE_CYCLES edges.
- **LONG timing:** fires LONG_CYCLES edges after the PRESS event edge minus DEBOUNCE_CYCLES, i.e. LONG_CYCLES stable-pressed cycles counted from PRESS_DB entry.
- **Simultaneous events:** LONG and RELEASE cannot coincide in the same cycle. If they would, LONG takes precedence and RELEASE is emitted one cycle later.
- The handshake is registered; `evt_ready` has no combinational path to any output.

## Configuration
- `BTN_LONG_PRESS_EN` defined: hold counter and LONG event are present, as described above.
- `BTN_LONG_PRESS_EN` undefined: hold counter removed; code 3 is never produced; otherwise identical behaviour and latency.

## Structure
- Package `btn_evt_pkg`:
  - event code constants `EVT_PRESS`=2'd1, `EVT_RELEASE`=2'd2, `EVT_LONG`=2'd3;
  - the FSM state enum typedef.
- Sub-module `btn_sync`: parameterised two-flop synchroniser with reset value input; reused for other pins.

## Test plan
Use DEBOUNCE_CYCLES=4, LONG_CYCLES=20, `BTN_ACTIVE_LOW`=1.
- **Clean press:** `btn_raw` 1→0 held, `evt_ready`=1 → `btn_level`=1 and `evt_valid`=1 with code 1 on edge 7 for one cycle.
- **Bounce rejection:** `btn_raw` low 3 cycles, high 1, low steady → no event until 7 edges after the final fall; exactly one PRESS.
- **Long press:** hold 30 cycles, `evt_ready`=1 → PRESS at edge 7, LONG (3) at edge 23, no second LONG. Release → RELEASE (2) 7 edges later.
- **Overflow:** `evt_ready`=0 through press and release → buffer holds code 1; RELEASE dropped; `evt_overflow`=1 and stays 1. Raising `evt_ready` then drains code 1 only.
- **Accept plus new event same cycle:** `evt_ready` pulsed on the RELEASE emit edge with PRESS buffered → `evt_valid` stays 1, code becomes 2, no overflow.
- **Reset mid-hold:** `sys_rst_n`=0 for 1 cycle during HELD → all outputs 0. With the button still held, PRESS fires 7 edges after reset release.
